wrr_burst_arbiter: RTL and testbench
====================================

// Module: wrr_burst_arbiter
// PURPOSE
//  Weighted round-robin arbiter granting a shared burst resource (bus/port) to N requesters.
//  Each grant lasts one whole burst, ended by the owner's last; per-requester credits set its burst share per round.
//  Sits between requester FIFOs and the shared datapath mux; grant_id drives the mux select.
// PARAMETERS
//  N          4  number of requesters (>=2)
//  WEIGHT_W   4  width of each weight/credit field
//  DEF_WEIGHT 1  weight/credit of every requester after reset
//  MAX_HOLD 255  cycles a grant may be held before forced release (WRR_ARB_TIMEOUT_EN only)
// PORTS
//  clk         in  1            clock, all logic on rising edge
//  rst         in  1            asynchronous, active-high reset
//  enable      in  1            allow new grants; never preempts a burst in progress
//  req         in  N            request per requester, held high until its burst ends
//  last        in  N            final beat of the owner's burst; qualified by grant
//  weight_cfg  in  N*WEIGHT_W   weights; field i = bits [i*WEIGHT_W +: WEIGHT_W]
//  cfg_load    in  1            one-cycle strobe: capture weight_cfg
//  grant       out N            one-hot grant, registered
//  grant_id    out $clog2(N)    index of granted requester; valid while grant_valid
//  grant_valid out 1            |grant
//  timeout_err out 1            one-cycle pulse on forced release
// BEHAVIOUR
//  Reset: grant=0, grant_id=0, grant_valid=0, timeout_err=0, ptr=0, FSM=IDLE.
//  Reset: weights and credits = DEF_WEIGHT, reload_pend=0.
//  Weight value 0 is treated as 1 when loaded into credits.
//  FSM IDLE / OWN / REFILL:
//   IDLE, reload_pend=1: credits<=weights, clear reload_pend, no grant this cycle.
//   IDLE, enable & |req, a requester has req & credit!=0: pick the first such from ptr upward, wrapping at N-1->0.
//     Next edge: grant[w]=1, grant_id=w, go OWN.
//   IDLE, enable & |req, every requester with req has credit=0: go REFILL.
//   REFILL: credits<=weights for all requesters, go IDLE (1 cycle).
//  OWN (owner g): grant held. End-of-burst = req[g]&last[g], or req[g]==0 (abandon).
//   End-of-burst: credit[g]-=1. If the new credit is 0, ptr<=(g+1)%N; otherwise ptr<=g.
//   End-of-burst: grant<=0 next edge, go IDLE. Min 1 idle cycle between grants.
//  Latency: req rises at cycle t in IDLE -> grant visible at t+1.
//  last[i] for i!=g is ignored. req changes of non-owners during OWN do not affect grant.
//  enable low in OWN: burst completes normally; no new grant until enable returns high.
//  cfg_load: weights captured the same edge; sets reload_pend.
//   Credits reload at the next IDLE cycle; never mid-burst.
//  cfg_load during a REFILL cycle: REFILL uses old weights, reload_pend still set.
//  rst mid-burst: grant drops immediately (async); all state returns to reset values.
// CONFIGURATION
//  `WRR_ARB_TIMEOUT_EN defined: 8+ bit hold counter, cleared on entering OWN.
//   After MAX_HOLD cycles in OWN without end-of-burst: forced release.
//   Forced release: credit[g]=0, ptr<=(g+1)%N, timeout_err pulses 1 cycle with grant drop, go IDLE.
//  Not defined: no counter; timeout_err tied 0; grant is held indefinitely until end-of-burst.
// STRUCTURE
//  Package wrr_arb_pkg: state enum (IDLE/OWN/REFILL), IDX_W=$clog2(N) helper function.
//  Sub-module rr_pick: combinational rotate-priority pick.
//   Inputs: candidate vector (req & credit!=0), ptr.
//   Outputs: one-hot + index + found flag.
//  Top holds the FSM, credit counters, weight registers, ptr and timeout counter.
// TESTING
//  1 Reset, weights 1, req=4'b1111, 1-beat bursts -> grants 0,1,2,3,0 in order; each 1 cycle, 1-cycle gaps.
//  2 weights {3,1,1,1} via cfg_load, all req -> requester 0 gets 3 bursts.
//    Then 1,2,3 once each, REFILL cycle, repeat.
//  3 req=4'b0100 only -> grant=4'b0100 at t+1.
//    Hold last=0 for 10 cycles -> grant stays. last=1 -> grant=0 next cycle.
//  4 Owner 2 in burst, enable=0, req[0]=1 -> burst 2 finishes.
//    No grant while enable=0; grant 0 one cycle after enable=1.
//  5 rst pulsed mid-burst -> grant=0 immediately.
//    After release: ptr=0 and credits=DEF_WEIGHT (req=1111 grants requester 0 first).
//  6 TIMEOUT_EN, MAX_HOLD=8, owner 1 never asserts last -> release after 8 cycles.
//    timeout_err=1 for 1 cycle; next grant goes to requester 2.

Source files
------------

// File: rtl/wrr_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wrr_arb_pkg
//  Purpose  : Shared types and helpers for the weighted round-robin burst
//             arbiter (state encoding, index-width helper).
//  Revision : 1.0  initial release
// ============================================================================
package wrr_arb_pkg;

    // Arbiter FSM states, explicitly encoded in two bits
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN    = 2'd1,
        REFILL = 2'd2
    } arb_state_t;

    // Width of a requester index; never less than one bit
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Purpose  : Combinational rotate-priority picker. Returns the first set
//             candidate at or after ptr, wrapping from N-1 to 0, as one-hot,
//             index and found flag.
//  Revision : 1.0  initial release
// ============================================================================
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     cand,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     onehot,
    output logic [IDX_W-1:0] idx,
    output logic             found
);

    // Scan offsets 0..N-1 from ptr; the first candidate hit wins
    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int i = 0; i < N; i++) begin
                if (!found && cand[i] && (((i + N - int'(ptr)) % N) == k)) begin
                    found     = 1'b1;
                    onehot[i] = 1'b1;
                    idx       = IDX_W'(i);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wrr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : wrr_burst_arbiter
//  Purpose  : Weighted round-robin arbiter for a shared burst resource.
//             A grant lasts one whole burst; per-requester credits set the
//             number of bursts each requester gets per round.
//  Options  : WRR_ARB_TIMEOUT_EN - forced release after MAX_HOLD cycles
//  Revision : 1.0  initial release
// ============================================================================
module wrr_burst_arbiter
    import wrr_arb_pkg::*;
#(
    parameter int N          = 4,
    parameter int WEIGHT_W   = 4,
    parameter int DEF_WEIGHT = 1,
    parameter int MAX_HOLD   = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [N-1:0]          req,
    input  logic [N-1:0]          last,
    input  logic [N*WEIGHT_W-1:0] weight_cfg,
    input  logic                  cfg_load,
    output logic [N-1:0]          grant,
    output logic [idx_w(N)-1:0]   grant_id,
    output logic                  grant_valid,
    output logic                  timeout_err
);

    localparam int c_idx_w = idx_w(N);
    localparam logic [WEIGHT_W-1:0] c_def_weight = WEIGHT_W'(DEF_WEIGHT);

    arb_state_t             r_state;
    arb_state_t             w_state_nxt;

    logic [WEIGHT_W-1:0]    r_weight [N];
    logic [WEIGHT_W-1:0]    r_credit [N];
    logic [WEIGHT_W-1:0]    w_load   [N];
    logic                   r_reload_pend;
    logic [c_idx_w-1:0]     r_ptr;
    logic [N-1:0]           r_grant;
    logic [c_idx_w-1:0]     r_grant_id;

    logic [N-1:0]           w_cand;
    logic [N-1:0]           w_pick_onehot;
    logic [c_idx_w-1:0]     w_pick_idx;
    logic                   w_pick_found;

    logic                   w_own_req;
    logic                   w_own_last;
    logic                   w_eob;
    logic [WEIGHT_W-1:0]    w_credit_own;
    logic [WEIGHT_W-1:0]    w_credit_dec;
    logic [c_idx_w-1:0]     w_next_idx;

    logic                   w_do_reload;
    logic                   w_do_refill;
    logic                   w_do_grant;
    logic                   w_do_release;
    logic                   w_do_timeout;
    logic                   w_hold_expired;

    // Candidates need a request and remaining credit; a zero weight loads as 1
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_req
            assign w_cand[gi] = req[gi] & (r_credit[gi] != '0);
            assign w_load[gi] = (r_weight[gi] == '0) ? WEIGHT_W'(1) : r_weight[gi];
        end
    endgenerate

    rr_pick #(
        .N     (N),
        .IDX_W (c_idx_w)
    ) u_rr_pick (
        .cand   (w_cand),
        .ptr    (r_ptr),
        .onehot (w_pick_onehot),
        .idx    (w_pick_idx),
        .found  (w_pick_found)
    );

    // Owner-side view: only the granted requester's req/last matter
    assign w_own_req    = req[r_grant_id];
    assign w_own_last   = last[r_grant_id];
    assign w_eob        = (w_own_req & w_own_last) | ~w_own_req;
    assign w_credit_own = r_credit[r_grant_id];
    assign w_credit_dec = (w_credit_own != '0) ? (w_credit_own - WEIGHT_W'(1)) : '0;
    assign w_next_idx   = (r_grant_id == c_idx_w'(N - 1)) ? '0 : (r_grant_id + c_idx_w'(1));

`ifdef WRR_ARB_TIMEOUT_EN
    localparam int c_hold_w = ($clog2(MAX_HOLD + 1) > 8) ? $clog2(MAX_HOLD + 1) : 8;

    logic [c_hold_w-1:0] r_hold_cnt;
    logic                r_timeout_err;

    assign w_hold_expired = (r_hold_cnt >= c_hold_w'(MAX_HOLD - 1));

    // Cycles spent in OWN for the current burst; restarts on each new grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (w_do_grant) begin
            r_hold_cnt <= '0;
        end else if (r_state == OWN && !w_hold_expired) begin
            r_hold_cnt <= r_hold_cnt + c_hold_w'(1);
        end
    end

    // Timeout flag pulses on the same edge the grant is dropped
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_do_timeout;
        end
    end

    assign timeout_err = r_timeout_err;
`else
    // Hold limit has no effect without the timeout option
    logic [31:0] w_unused_max_hold;
    assign w_unused_max_hold = 32'(MAX_HOLD);
    assign w_hold_expired    = 1'b0;
    assign timeout_err       = 1'b0;
`endif

    // Next-state and action decode; reload has priority over a new grant
    always_comb begin
        w_state_nxt  = r_state;
        w_do_reload  = 1'b0;
        w_do_refill  = 1'b0;
        w_do_grant   = 1'b0;
        w_do_release = 1'b0;
        w_do_timeout = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_reload_pend) begin
                    w_do_reload = 1'b1;
                end else if (enable && (|req)) begin
                    if (w_pick_found) begin
                        w_do_grant  = 1'b1;
                        w_state_nxt = OWN;
                    end else begin
                        w_state_nxt = REFILL;
                    end
                end
            end
            OWN: begin
                if (w_eob) begin
                    w_do_release = 1'b1;
                    w_state_nxt  = IDLE;
                end else if (w_hold_expired) begin
                    w_do_timeout = 1'b1;
                    w_state_nxt  = IDLE;
                end
            end
            REFILL: begin
                w_do_refill = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Weight registers capture the config bus on the load strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_weight[i] <= c_def_weight;
        end else if (cfg_load) begin
            for (int i = 0; i < N; i++) r_weight[i] <= weight_cfg[i*WEIGHT_W +: WEIGHT_W];
        end
    end

    // A new config wins over clearing, so a load during reload is not lost
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_reload_pend <= 1'b0;
        end else if (cfg_load) begin
            r_reload_pend <= 1'b1;
        end else if (w_do_reload) begin
            r_reload_pend <= 1'b0;
        end
    end

    // Credits: bulk reload from the (pre-load) weights, or owner update at burst end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N; i++) r_credit[i] <= c_def_weight;
        end else if (w_do_reload || w_do_refill) begin
            for (int i = 0; i < N; i++) r_credit[i] <= w_load[i];
        end else if (w_do_release) begin
            r_credit[r_grant_id] <= w_credit_dec;
        end else if (w_do_timeout) begin
            r_credit[r_grant_id] <= '0;
        end
    end

    // Priority pointer stays on the owner while it still has credit
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (w_do_release) begin
            r_ptr <= (w_credit_dec == '0) ? w_next_idx : r_grant_id;
        end else if (w_do_timeout) begin
            r_ptr <= w_next_idx;
        end
    end

    // Registered grant; id keeps its last value after release
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant    <= '0;
            r_grant_id <= '0;
        end else if (w_do_grant) begin
            r_grant    <= w_pick_onehot;
            r_grant_id <= w_pick_idx;
        end else if (w_do_release || w_do_timeout) begin
            r_grant    <= '0;
        end
    end

    assign grant       = r_grant;
    assign grant_id    = r_grant_id;
    assign grant_valid = |r_grant;

endmodule
`default_nettype wire

// File: tb/tb_wrr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wrr_burst_arbiter
//  Purpose  : Directed self-checking bench for wrr_burst_arbiter
//             (N=4, WEIGHT_W=4). Timeout scenario runs only when
//             WRR_ARB_TIMEOUT_EN is defined.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wrr_burst_arbiter;

`ifdef WRR_ARB_TIMEOUT_EN
    localparam int MAXH = 8;
`else
    localparam int MAXH = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        enable;
    logic [3:0]  req;
    logic [3:0]  last;
    logic [15:0] weight_cfg;
    logic        cfg_load;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic        timeout_err;

    int n_chk = 0;
    int n_err = 0;

    wrr_burst_arbiter #(
        .N          (4),
        .WEIGHT_W   (4),
        .DEF_WEIGHT (1),
        .MAX_HOLD   (MAXH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .req         (req),
        .last        (last),
        .weight_cfg  (weight_cfg),
        .cfg_load    (cfg_load),
        .grant       (grant),
        .grant_id    (grant_id),
        .grant_valid (grant_valid),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    // Safety net so the run always ends
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [1:0] oh2id(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) if (oh[i]) r = 2'(i);
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] eg, input logic et);
        n_chk++;
        assert (grant === eg) else begin
            n_err++;
            $error("FAIL %s grant: got %b expected %b", tag, grant, eg);
        end
        n_chk++;
        assert (grant_valid === (|eg)) else begin
            n_err++;
            $error("FAIL %s grant_valid: got %b expected %b", tag, grant_valid, |eg);
        end
        if (eg != 4'b0000) begin
            n_chk++;
            assert (grant_id === oh2id(eg)) else begin
                n_err++;
                $error("FAIL %s grant_id: got %0d expected %0d", tag, grant_id, oh2id(eg));
            end
        end
        n_chk++;
        assert (timeout_err === et) else begin
            n_err++;
            $error("FAIL %s timeout_err: got %b expected %b", tag, timeout_err, et);
        end
    endtask

    task automatic do_reset();
        req        = 4'b0000;
        last       = 4'b0000;
        enable     = 1'b1;
        cfg_load   = 1'b0;
        weight_cfg = 16'h0000;
        rst        = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    logic [3:0] t1 [12];
    logic [3:0] t2 [18];

    initial begin
        t1 = '{4'h1, 4'h0, 4'h2, 4'h0, 4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0};
        t2 = '{4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h1, 4'h0, 4'h2, 4'h0,
               4'h4, 4'h0, 4'h8, 4'h0, 4'h0, 4'h0, 4'h1, 4'h0, 4'h1};

        // ---- reset state ----
        req = 4'b0000; last = 4'b0000; enable = 1'b1; cfg_load = 1'b0; weight_cfg = 16'h0;
        rst = 1'b1;
        #2;
        chk("reset_async", 4'b0000, 1'b0);
        n_chk++;
        assert (grant_id === 2'd0) else begin
            n_err++;
            $error("FAIL reset grant_id: got %0d expected 0", grant_id);
        end
        step();
        rst = 1'b0;
        step();
        chk("reset_idle", 4'b0000, 1'b0);

        // ---- 1: equal weights, 1-beat bursts, round robin with refill ----
        do_reset();
        req = 4'b1111; last = 4'b1111;
        for (int k = 0; k < 12; k++) begin
            step();
            chk($sformatf("t1_%0d", k), t1[k], 1'b0);
        end

        // ---- 2: weights {w3=0(->1), w2=1, w1=1, w0=3} ----
        do_reset();
        weight_cfg = 16'h0113; cfg_load = 1'b1;
        step();
        cfg_load = 1'b0; req = 4'b1111; last = 4'b1111;
        for (int k = 0; k < 18; k++) begin
            step();
            chk($sformatf("t2_%0d", k), t2[k], 1'b0);
        end

        // ---- 3: single requester, long hold, foreign last ignored ----
        do_reset();
        req = 4'b0100; last = 4'b0000;
        step();
        chk("t3_grant", 4'b0100, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk($sformatf("t3_hold_%0d", k), 4'b0100, 1'b0);
            if (k == 4) begin
                req  = 4'b0101;
                last = 4'b0001;
            end
        end
        last = 4'b0101;
        step();
        chk("t3_release", 4'b0000, 1'b0);
        step();
        chk("t3_next_wrap", 4'b0001, 1'b0);
        step();
        chk("t3_next_rel", 4'b0000, 1'b0);
        req = 4'b0000; last = 4'b0000;

        // ---- 4: enable low during burst ----
        do_reset();
        req = 4'b0100; last = 4'b0000;
        step();
        chk("t4_grant2", 4'b0100, 1'b0);
        enable = 1'b0; req = 4'b0101;
        step();
        chk("t4_hold", 4'b0100, 1'b0);
        last = 4'b0100;
        step();
        chk("t4_finish", 4'b0000, 1'b0);
        last = 4'b0000; req = 4'b0001;
        for (int k = 0; k < 3; k++) begin
            step();
            chk($sformatf("t4_dis_%0d", k), 4'b0000, 1'b0);
        end
        enable = 1'b1;
        step();
        chk("t4_en_grant0", 4'b0001, 1'b0);
        last = 4'b0001;
        step();
        chk("t4_rel0", 4'b0000, 1'b0);

        // ---- 5: reset mid-burst ----
        req = 4'b0010; last = 4'b0000;
        step();
        chk("t5_grant1", 4'b0010, 1'b0);
        step();
        chk("t5_hold1", 4'b0010, 1'b0);
        rst = 1'b1;
        #1;
        chk("t5_async_drop", 4'b0000, 1'b0);
        step();
        rst = 1'b0;
        req = 4'b1111; last = 4'b0000;
        step();
        chk("t5_after_rst", 4'b0001, 1'b0);
        last = 4'b1111;
        step();
        chk("t5_rel", 4'b0000, 1'b0);
        step();
        chk("t5_next", 4'b0010, 1'b0);
        req = 4'b0000; last = 4'b0000;

`ifdef WRR_ARB_TIMEOUT_EN
        // ---- 6: forced release after MAX_HOLD cycles ----
        do_reset();
        req = 4'b0010; last = 4'b0000;
        step();
        chk("t6_grant1", 4'b0010, 1'b0);
        for (int k = 0; k < 7; k++) begin
            step();
            chk($sformatf("t6_hold_%0d", k), 4'b0010, 1'b0);
        end
        step();
        chk("t6_timeout", 4'b0000, 1'b1);
        req = 4'b1111;
        step();
        chk("t6_next2", 4'b0100, 1'b0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
